ttl_sync_counter_n: RTL and testbench



---
 rtl/ttl_sync_counter_n_if.sv | 24 ++
 rtl/ttl_sync_counter_n.sv | 77 +++++++
 tb/tb_ttl_sync_counter_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ttl_sync_counter_n_if.sv
// Control, data and status bundle of a ttl_sync_counter_n stage.
// The master drives the load/enable/direction pins; the counter (slave) returns its state and flags.
interface ttl_sync_counter_n_if #(
   parameter int WIDTH = 4
);
   logic             LOAD_N;
   logic             ENP;
   logic             ENT;
   logic             DOWN;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             RCO;
   logic             MAXMIN;

   modport master (
      output LOAD_N, ENP, ENT, DOWN, D,
      input  Q, RCO, MAXMIN
   );

   modport slave (
      input  LOAD_N, ENP, ENT, DOWN, D,
      output Q, RCO, MAXMIN
   );
endinterface

// File: rtl/ttl_sync_counter_n.sv
// Cascadable synchronous presettable modulo-N up/down counter (74161/74191 style)
// with supply-pin modelling: an unpowered part ignores clock and clear and keeps its state.
module ttl_sync_counter_n #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int RESET_VAL = 0
) (
   input  logic                  CLK,
   input  logic                  CLR_N,
   input  logic                  VCC,
   input  logic                  GND,
   ttl_sync_counter_n_if.slave   bus
);

   localparam logic [WIDTH-1:0] ZERO_Q  = WIDTH'(32'd0);
   localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(32'd1);
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 32'sd1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
   localparam logic [16:0]      MOD_EXT = 17'(MODULUS);

   logic             pg_s;
   logic             clr_gated_n_s;
   logic [16:0]      d_ext_s;
   logic [WIDTH-1:0] load_val_s;
   logic [WIDTH-1:0] q_next_s;
   logic             ts_s;
   logic [WIDTH-1:0] q_r;

   assign pg_s          = VCC & ~GND;
   // Clear only reaches the flops while powered; power returning under a held clear applies it then.
   assign clr_gated_n_s = CLR_N | ~pg_s;

   assign d_ext_s    = 17'(bus.D);
   assign load_val_s = WIDTH'(d_ext_s % MOD_EXT);

   // Next-state selection: load beats count, count needs both enables.
   always_comb begin
      q_next_s = q_r;
      if (!bus.LOAD_N) begin
         q_next_s = load_val_s;
      end else if (bus.ENP && bus.ENT) begin
         if (!bus.DOWN) begin
            q_next_s = (q_r == MAX_Q) ? ZERO_Q : (q_r + ONE_Q);
         end else begin
            q_next_s = (q_r == ZERO_Q) ? MAX_Q : (q_r - ONE_Q);
         end
      end else begin
         q_next_s = q_r;
      end
   end

   // Counter state: async clear when powered, frozen whenever power is bad.
   always_ff @(posedge CLK or negedge clr_gated_n_s) begin
      if (!clr_gated_n_s) begin
         q_r <= RST_Q;
      end else if (pg_s) begin
         q_r <= q_next_s;
      end else begin
         q_r <= q_r;
      end
   end

   // Terminal state depends on the live direction pin, so the flags follow DOWN between edges.
   always_comb begin
      ts_s = 1'b0;
      if (bus.DOWN) begin
         ts_s = (q_r == ZERO_Q);
      end else begin
         ts_s = (q_r == MAX_Q);
      end
   end

   assign bus.Q      = q_r;
   assign bus.MAXMIN = ts_s;
   assign bus.RCO    = ts_s & bus.ENT;

endmodule

// File: tb/tb_ttl_sync_counter_n.sv
// Self-checking bench for ttl_sync_counter_n: a modulo-10 part plus a two-stage modulo-16 chain.
module tb_ttl_sync_counter_n;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic clr_n;
   logic vcc;
   logic gnd;
   logic clr_c_n;
   logic vcc_c;
   logic gnd_c;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];

   ttl_sync_counter_n_if #(.WIDTH(4)) bus ();
   ttl_sync_counter_n_if #(.WIDTH(4)) bus_c0 ();
   ttl_sync_counter_n_if #(.WIDTH(4)) bus_c1 ();

   ttl_sync_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .CLK(CLK), .CLR_N(clr_n), .VCC(vcc), .GND(gnd), .bus(bus)
   );

   ttl_sync_counter_n #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) stage0 (
      .CLK(CLK), .CLR_N(clr_c_n), .VCC(vcc_c), .GND(gnd_c), .bus(bus_c0)
   );

   ttl_sync_counter_n #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) stage1 (
      .CLK(CLK), .CLR_N(clr_c_n), .VCC(vcc_c), .GND(gnd_c), .bus(bus_c1)
   );

   assign bus_c1.ENT = bus_c0.RCO;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; vcc = 1'b1; gnd = 1'b0;
      bus.LOAD_N = 1'b1; bus.ENP = 1'b1; bus.ENT = 1'b1; bus.DOWN = 1'b0; bus.D = 4'h0;
      #3;
      checks++;
      if (bus.Q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.Q); end
      checks++;
      if (bus.MAXMIN !== 1'b0 || bus.RCO !== 1'b0) begin
         failures++; $display("FAIL reset_flags_up got=%b%b exp=00", bus.MAXMIN, bus.RCO);
      end
      tick();
      checks++;
      if (bus.Q !== 4'd0) begin failures++; $display("FAIL reset_hold_edge got=%0d exp=0", bus.Q); end
      bus.DOWN = 1'b1;
      #1;
      checks++;
      if (bus.MAXMIN !== 1'b1 || bus.RCO !== 1'b1) begin
         failures++; $display("FAIL reset_flags_down got=%b%b exp=11", bus.MAXMIN, bus.RCO);
      end
      bus.DOWN = 1'b0;
      #2;
      clr_n = 1'b1;
   endtask

   task automatic test_count_up();
      int model = 0;
      int e;
      for (int i = 0; i < 12; i++) begin
         model = (model == 9) ? 0 : model + 1;
         exp_q.push_back(model);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.Q !== 4'(e)) begin failures++; $display("FAIL count_up_q step=%0d got=%0d exp=%0d", i, bus.Q, e); end
         checks++;
         if (bus.RCO !== ((e == 9) ? 1'b1 : 1'b0)) begin
            failures++; $display("FAIL count_up_rco step=%0d got=%b q=%0d", i, bus.RCO, e);
         end
      end
   endtask

   task automatic test_async_clear();
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (bus.Q !== 4'd5) begin failures++; $display("FAIL clear_setup got=%0d exp=5", bus.Q); end
      #3;
      clr_n = 1'b0;
      #1;
      checks++;
      if (bus.Q !== 4'd0) begin failures++; $display("FAIL clear_async got=%0d exp=0", bus.Q); end
      tick();
      checks++;
      if (bus.Q !== 4'd0) begin failures++; $display("FAIL clear_edge_ignored got=%0d exp=0", bus.Q); end
      bus.ENP = 1'b0;
      clr_n = 1'b1;
   endtask

   task automatic test_load_down();
      logic [3:0] d_tab [4] = '{4'hC, 4'hF, 4'h7, 4'hC};
      int         q_tab [4] = '{2, 5, 7, 2};
      int         dn_tab [3] = '{1, 0, 9};
      int e;
      bus.ENP = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.LOAD_N = 1'b0;
         bus.D = d_tab[i];
         exp_q.push_back(q_tab[i]);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.Q !== 4'(e)) begin failures++; $display("FAIL load_q d=%h got=%0d exp=%0d", d_tab[i], bus.Q, e); end
      end
      bus.LOAD_N = 1'b1; bus.DOWN = 1'b1; bus.ENP = 1'b1; bus.ENT = 1'b1;
      #1;
      checks++;
      if (bus.RCO !== 1'b0) begin failures++; $display("FAIL down_rco_q2 got=%b exp=0", bus.RCO); end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(dn_tab[i]);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.Q !== 4'(e)) begin failures++; $display("FAIL down_q step=%0d got=%0d exp=%0d", i, bus.Q, e); end
         checks++;
         if (bus.RCO !== ((e == 0) ? 1'b1 : 1'b0)) begin
            failures++; $display("FAIL down_rco step=%0d got=%b q=%0d", i, bus.RCO, e);
         end
      end
   endtask

   task automatic test_ent_gating();
      bus.DOWN = 1'b0; bus.ENP = 1'b1; bus.ENT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.Q !== 4'd9) begin failures++; $display("FAIL ent_hold_q step=%0d got=%0d exp=9", i, bus.Q); end
         checks++;
         if (bus.MAXMIN !== 1'b1 || bus.RCO !== 1'b0) begin
            failures++; $display("FAIL ent_hold_flags got=%b%b exp=10", bus.MAXMIN, bus.RCO);
         end
      end
      bus.ENT = 1'b1;
      #1;
      checks++;
      if (bus.RCO !== 1'b1) begin failures++; $display("FAIL ent_rco_comb got=%b exp=1", bus.RCO); end
      bus.DOWN = 1'b1;
      #1;
      checks++;
      if (bus.MAXMIN !== 1'b0 || bus.RCO !== 1'b0) begin
         failures++; $display("FAIL down_flip_flags got=%b%b exp=00", bus.MAXMIN, bus.RCO);
      end
   endtask

   task automatic test_cascade();
      int model = 0;
      int e;
      clr_c_n = 1'b0; vcc_c = 1'b1; gnd_c = 1'b0;
      bus_c0.LOAD_N = 1'b1; bus_c0.ENP = 1'b1; bus_c0.ENT = 1'b1; bus_c0.DOWN = 1'b0; bus_c0.D = 4'h0;
      bus_c1.LOAD_N = 1'b1; bus_c1.ENP = 1'b1; bus_c1.DOWN = 1'b0; bus_c1.D = 4'h0;
      #2;
      clr_c_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         model = (model + 1) % 256;
         exp_q.push_back(model);
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({bus_c1.Q, bus_c0.Q} !== 8'(e)) begin
            failures++; $display("FAIL cascade_q step=%0d got=%h exp=%h", i, {bus_c1.Q, bus_c0.Q}, 8'(e));
         end
      end
      checks++;
      if ({bus_c1.Q, bus_c0.Q} !== 8'h14) begin
         failures++; $display("FAIL cascade_final got=%h exp=14", {bus_c1.Q, bus_c0.Q});
      end
   endtask

   task automatic test_power_loss();
      bus.DOWN = 1'b0; bus.ENP = 1'b0; bus.LOAD_N = 1'b0; bus.D = 4'd3;
      tick();
      checks++;
      if (bus.Q !== 4'd3) begin failures++; $display("FAIL power_setup got=%0d exp=3", bus.Q); end
      bus.LOAD_N = 1'b1; bus.ENP = 1'b1; bus.ENT = 1'b1;
      vcc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            #2; clr_n = 1'b0; #2;
            checks++;
            if (bus.Q !== 4'd3) begin failures++; $display("FAIL power_clr_ignored got=%0d exp=3", bus.Q); end
            clr_n = 1'b1;
         end
         tick();
         checks++;
         if (bus.Q !== 4'd3) begin failures++; $display("FAIL power_frozen step=%0d got=%0d exp=3", i, bus.Q); end
      end
      vcc = 1'b1;
      exp_q.push_back(4);
      tick();
      checks++;
      if (bus.Q !== 4'(exp_q.pop_front())) begin failures++; $display("FAIL power_resume got=%0d exp=4", bus.Q); end
      gnd = 1'b1;
      tick();
      checks++;
      if (bus.Q !== 4'd4) begin failures++; $display("FAIL gnd_frozen got=%0d exp=4", bus.Q); end
      gnd = 1'b0;
      tick();
      checks++;
      if (bus.Q !== 4'd5) begin failures++; $display("FAIL gnd_resume got=%0d exp=5", bus.Q); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_count_up();
      test_async_clear();
      test_load_down();
      test_ent_gating();
      test_cascade();
      test_power_loss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
